// File: rtl/spi_xfer_sequencer.sv
// rtl/spi_xfer_sequencer.sv - byte-transfer sequencer between TX/RX FIFOs and an SPI master
module spi_xfer_sequencer #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                   PCLK,
    input  logic                   PRESET,
    input  logic                   SEQ_EN,
    input  logic                   TX_WR_EN,
    input  logic [7:0]             TX_WDATA,
    input  logic                   RX_RD_EN,
    output logic [7:0]             RX_RDATA,
    output logic                   TX_FULL,
    output logic                   TX_EMPTY,
    output logic                   RX_FULL,
    output logic                   RX_EMPTY,
    output logic [$clog2(DEPTH):0] TX_LEVEL,
    output logic [$clog2(DEPTH):0] RX_LEVEL,
    output logic [2:0]             ERR,
    input  logic [2:0]             ERR_CLR,
    output logic [7:0]             SPI_DATA,
    output logic                   SPI_SEL_DATA,
    output logic                   SPI_SEL_CMD,
    input  logic                   SPI_RX_PULSE,
    input  logic [7:0]             SPI_RX_DATA,
    output logic                   BUSY
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
    localparam logic [7:0]  TMO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_WAIT, S_CAPTURE} state_t;

    state_t        state_q, state_d;
    logic [7:0]    tx_mem_q [DEPTH];
    logic [7:0]    rx_mem_q [DEPTH];
    logic [AW-1:0] tx_wr_q, tx_rd_q, rx_wr_q, rx_rd_q;
    logic [AW:0]   tx_lvl_q, rx_lvl_q;
    logic [7:0]    spi_data_q, wait_cnt_q, wait_cnt_d;
    logic [2:0]    err_q, err_set;
    logic          tx_push, tx_pop, rx_push, rx_pop;

    assign TX_FULL  = (tx_lvl_q == FULL_LVL);
    assign TX_EMPTY = (tx_lvl_q == '0);
    assign RX_FULL  = (rx_lvl_q == FULL_LVL);
    assign RX_EMPTY = (rx_lvl_q == '0);
    assign TX_LEVEL = tx_lvl_q;
    assign RX_LEVEL = rx_lvl_q;
    assign ERR      = err_q;
    assign BUSY     = (state_q != S_IDLE);

    // Fullness is judged on registered levels, so a push at full is dropped even when LOAD pops.
    assign tx_push = TX_WR_EN && !TX_FULL;
    assign tx_pop  = (state_q == S_LOAD);
    assign rx_push = (state_q == S_CAPTURE);
    assign rx_pop  = RX_RD_EN && !RX_EMPTY;

    assign SPI_SEL_DATA = (state_q == S_LOAD);
    assign SPI_SEL_CMD  = (state_q == S_START);
    assign SPI_DATA     = (state_q == S_LOAD) ? tx_mem_q[tx_rd_q] : spi_data_q;
    assign RX_RDATA     = RX_EMPTY ? 8'h00 : rx_mem_q[rx_rd_q];

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        err_set    = 3'b000;
        err_set[0] = TX_WR_EN && TX_FULL;
        err_set[1] = RX_RD_EN && RX_EMPTY;
        case (state_q)
            S_IDLE:    if (SEQ_EN && !TX_EMPTY && !RX_FULL) state_d = S_LOAD;
            S_LOAD:    state_d = S_START;
            S_START: begin
                wait_cnt_d = 8'd0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                wait_cnt_d = wait_cnt_q + 8'd1;
                if (SPI_RX_PULSE) begin
                    state_d = S_CAPTURE;
                end else if (wait_cnt_q == TMO_LAST) begin
                    err_set[2] = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            S_CAPTURE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q    <= S_IDLE;
            tx_wr_q    <= '0;
            tx_rd_q    <= '0;
            rx_wr_q    <= '0;
            rx_rd_q    <= '0;
            tx_lvl_q   <= '0;
            rx_lvl_q   <= '0;
            spi_data_q <= 8'h00;
            wait_cnt_q <= 8'd0;
            err_q      <= 3'b000;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            err_q      <= (err_q & ~ERR_CLR) | err_set;
            if (tx_push) tx_wr_q <= tx_wr_q + 1'b1;
            if (tx_pop) begin
                tx_rd_q    <= tx_rd_q + 1'b1;
                spi_data_q <= tx_mem_q[tx_rd_q];
            end
            if (rx_push) rx_wr_q <= rx_wr_q + 1'b1;
            if (rx_pop)  rx_rd_q <= rx_rd_q + 1'b1;
            tx_lvl_q <= tx_lvl_q + (AW+1)'(tx_push) - (AW+1)'(tx_pop);
            rx_lvl_q <= rx_lvl_q + (AW+1)'(rx_push) - (AW+1)'(rx_pop);
        end
    end

    always_ff @(posedge PCLK) begin
        if (tx_push) tx_mem_q[tx_wr_q] <= TX_WDATA;
        if (rx_push) rx_mem_q[rx_wr_q] <= SPI_RX_DATA;
    end
endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// tb/tb_spi_xfer_sequencer.sv - self-checking bench for spi_xfer_sequencer
module tb_spi_xfer_sequencer;
    localparam int DEPTH = 4;
    localparam int TMO   = 10;

    logic       PCLK = 1'b0, PRESET = 1'b1, SEQ_EN = 1'b0;
    logic       TX_WR_EN = 1'b0, RX_RD_EN = 1'b0, SPI_RX_PULSE = 1'b0;
    logic [7:0] TX_WDATA = 8'h00, SPI_RX_DATA = 8'h00;
    logic [2:0] ERR_CLR = 3'b000;
    logic [7:0] RX_RDATA, SPI_DATA;
    logic       TX_FULL, TX_EMPTY, RX_FULL, RX_EMPTY, SPI_SEL_DATA, SPI_SEL_CMD, BUSY;
    logic [2:0] TX_LEVEL, RX_LEVEL, ERR;

    spi_xfer_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .SEQ_EN(SEQ_EN),
        .TX_WR_EN(TX_WR_EN), .TX_WDATA(TX_WDATA),
        .RX_RD_EN(RX_RD_EN), .RX_RDATA(RX_RDATA),
        .TX_FULL(TX_FULL), .TX_EMPTY(TX_EMPTY), .RX_FULL(RX_FULL), .RX_EMPTY(RX_EMPTY),
        .TX_LEVEL(TX_LEVEL), .RX_LEVEL(RX_LEVEL),
        .ERR(ERR), .ERR_CLR(ERR_CLR),
        .SPI_DATA(SPI_DATA), .SPI_SEL_DATA(SPI_SEL_DATA), .SPI_SEL_CMD(SPI_SEL_CMD),
        .SPI_RX_PULSE(SPI_RX_PULSE), .SPI_RX_DATA(SPI_RX_DATA), .BUSY(BUSY)
    );

    always #5 PCLK = ~PCLK;

    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    logic [2:0] err_m = 3'b000;
    int n_checks = 0;
    int n_fails  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    task automatic check_status(input string tag);
        chk({tag, "/tx_level"}, TX_LEVEL, tx_q.size());
        chk({tag, "/rx_level"}, RX_LEVEL, rx_q.size());
        chk({tag, "/tx_empty"}, TX_EMPTY, tx_q.size() == 0);
        chk({tag, "/tx_full"},  TX_FULL,  tx_q.size() == DEPTH);
        chk({tag, "/rx_empty"}, RX_EMPTY, rx_q.size() == 0);
        chk({tag, "/rx_full"},  RX_FULL,  rx_q.size() == DEPTH);
        chk({tag, "/err"},      ERR,      err_m);
        if (rx_q.size() > 0) chk({tag, "/rx_head"}, RX_RDATA, rx_q[0]);
    endtask

    task automatic push(input logic [7:0] b);
        if (tx_q.size() == DEPTH) err_m[0] = 1'b1;
        else tx_q.push_back(b);
        TX_WR_EN = 1'b1;
        TX_WDATA = b;
        step();
        TX_WR_EN = 1'b0;
    endtask

    task automatic pop_rx();
        if (rx_q.size() == 0) err_m[1] = 1'b1;
        else begin
            chk("pop_head", RX_RDATA, rx_q[0]);
            void'(rx_q.pop_front());
        end
        RX_RD_EN = 1'b1;
        step();
        RX_RD_EN = 1'b0;
    endtask

    task automatic wait_load(output logic [7:0] exp_tx);
        for (int i = 0; i < 20 && SPI_SEL_DATA !== 1'b1; i++) step();
        chk("load_seen", SPI_SEL_DATA, 1);
        chk("load_cmd_low", SPI_SEL_CMD, 0);
        exp_tx = 8'h00;
        if (tx_q.size() > 0) exp_tx = tx_q.pop_front();
        chk("load_data", SPI_DATA, exp_tx);
    endtask

    // One full transfer; optional TX push during LOAD and RX pop during CAPTURE.
    task automatic xfer(input logic [7:0] rxb, input bit push_load, input logic [7:0] pb,
                        input bit pop_cap);
        logic [7:0] exp_tx;
        bit was_full;
        was_full = (tx_q.size() == DEPTH);
        wait_load(exp_tx);
        if (push_load) begin
            if (was_full) err_m[0] = 1'b1;
            else tx_q.push_back(pb);
        end
        TX_WR_EN = push_load;
        TX_WDATA = pb;
        step();
        TX_WR_EN = 1'b0;
        chk("start_cmd", SPI_SEL_CMD, 1);
        chk("start_sel_data", SPI_SEL_DATA, 0);
        chk("start_hold", SPI_DATA, exp_tx);
        step();
        chk("wait_strobes", {SPI_SEL_DATA, SPI_SEL_CMD}, 0);
        repeat ($urandom_range(0, 6)) begin
            SPI_RX_DATA = 8'($urandom);
            step();
        end
        chk("wait_busy", BUSY, 1);
        SPI_RX_PULSE = 1'b1;
        SPI_RX_DATA  = ~rxb;
        step();
        SPI_RX_PULSE = 1'b0;
        SPI_RX_DATA  = rxb;
        chk("cap_busy", BUSY, 1);
        if (pop_cap) begin
            if (rx_q.size() == 0) err_m[1] = 1'b1;
            else begin
                chk("cap_pop_head", RX_RDATA, rx_q[0]);
                void'(rx_q.pop_front());
            end
        end
        RX_RD_EN = pop_cap;
        step();
        RX_RD_EN    = 1'b0;
        SPI_RX_DATA = 8'($urandom);
        rx_q.push_back(rxb);
        chk("done_busy", BUSY, 0);
        check_status("xfer");
    endtask

    initial begin
        logic [7:0] t;
        int g;
        step(); step();
        PRESET = 1'b0;
        check_status("reset");
        chk("reset_busy", BUSY, 0);
        chk("reset_spi_data", SPI_DATA, 8'h00);
        chk("reset_strobes", {SPI_SEL_DATA, SPI_SEL_CMD}, 0);
        chk("reset_rdata", RX_RDATA, 8'h00);

        SEQ_EN = 1'b1;
        push(8'hA5);
        xfer(8'h3C, 1'b0, 8'h00, 1'b0);
        chk("single_rdata", RX_RDATA, 8'h3C);

        pop_rx();
        pop_rx();
        check_status("pop_empty");
        ERR_CLR = 3'b010; RX_RD_EN = 1'b1;
        step();
        ERR_CLR = 3'b000; RX_RD_EN = 1'b0;
        check_status("set_beats_clr");
        ERR_CLR = 3'b010;
        step();
        ERR_CLR = 3'b000; err_m[1] = 1'b0;
        check_status("clr_err1");

        SEQ_EN = 1'b0;
        push(8'h01); push(8'h02); push(8'h03);
        SEQ_EN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            xfer(8'($urandom), 1'b0, 8'h00, 1'b0);
            if (i < 2) begin
                step();
                chk("spacing", SPI_SEL_DATA, 1);
            end
        end
        SEQ_EN = 1'b0;
        check_status("b2b");
        repeat (3) pop_rx();

        for (int i = 0; i < 5; i++) push(8'($urandom));
        check_status("tx_drop");
        ERR_CLR = 3'b001;
        push(8'($urandom));
        ERR_CLR = 3'b000;
        check_status("drop_beats_clr");
        ERR_CLR = 3'b001;
        step();
        ERR_CLR = 3'b000; err_m[0] = 1'b0;
        check_status("clr_err0");

        SEQ_EN = 1'b1;
        xfer(8'($urandom), 1'b1, 8'($urandom), 1'b0);
        step();
        SEQ_EN = 1'b0;
        xfer(8'($urandom), 1'b1, 8'($urandom), 1'b1);
        repeat (3) begin
            step();
            chk("seq_off_idle", BUSY, 0);
        end
        ERR_CLR = 3'b111;
        step();
        ERR_CLR = 3'b000; err_m = 3'b000;
        while (rx_q.size() > 0) pop_rx();
        check_status("drained");

        repeat (8) begin
            SEQ_EN = 1'b0;
            repeat ($urandom_range(1, 3)) push(8'($urandom));
            SEQ_EN = 1'b1;
            g = 0;
            while (tx_q.size() > 0 && rx_q.size() < DEPTH && g < 12) begin
                xfer(8'($urandom), 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
                if ($urandom_range(0, 1) == 1) pop_rx();
                g++;
            end
            SEQ_EN = 1'b0;
            step();
            chk("rand_idle", BUSY, 0);
            while (rx_q.size() > 0) pop_rx();
            check_status("rand_iter");
            ERR_CLR = 3'b111;
            step();
            ERR_CLR = 3'b000; err_m = 3'b000;
        end

        PRESET = 1'b1;
        step();
        PRESET = 1'b0;
        tx_q.delete(); rx_q.delete(); err_m = 3'b000;
        check_status("reset2");
        repeat (4) push(8'($urandom));
        SEQ_EN = 1'b1;
        repeat (4) xfer(8'($urandom), 1'b0, 8'h00, 1'b0);
        push(8'($urandom));
        repeat (4) begin
            step();
            chk("rx_full_stall", BUSY, 0);
        end
        pop_rx();
        chk("stall_after_pop", SPI_SEL_DATA, 0);
        step();
        chk("load_after_pop", SPI_SEL_DATA, 1);
        xfer(8'($urandom), 1'b0, 8'h00, 1'b0);

        SEQ_EN = 1'b0;
        pop_rx();
        push(8'($urandom));
        SEQ_EN = 1'b1;
        wait_load(t);
        step(); step();
        SEQ_EN = 1'b0;
        for (int k = 2; k <= TMO; k++) begin
            step();
            chk("tmo_wait", BUSY, 1);
        end
        step();
        chk("tmo_idle", BUSY, 0);
        err_m[2] = 1'b1;
        check_status("timeout");
        SPI_RX_PULSE = 1'b1; SPI_RX_DATA = 8'($urandom);
        step();
        SPI_RX_PULSE = 1'b0;
        step();
        check_status("late_pulse_idle");

        push(8'($urandom)); push(8'($urandom));
        SEQ_EN = 1'b1;
        wait_load(t);
        step(); step();
        chk("pre_reset_busy", BUSY, 1);
        PRESET = 1'b1;
        step();
        PRESET = 1'b0;
        tx_q.delete(); rx_q.delete(); err_m = 3'b000;
        chk("wait_reset_busy", BUSY, 0);
        check_status("wait_reset");
        SPI_RX_PULSE = 1'b1; SPI_RX_DATA = 8'($urandom);
        step();
        SPI_RX_PULSE = 1'b0;
        step();
        chk("post_reset_strobes", {SPI_SEL_DATA, SPI_SEL_CMD}, 0);
        step();
        check_status("post_reset_pulse");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/spi_xfer_sequencer.md
SPI_XFER_SEQUENCER -- requirements
Module: spi_xfer_sequencer

Interface
REQ-001 SHALL use one clock and a synchronous, active-high reset: PCLK is the single clock, and PRESET is sampled on the PCLK rising edge.
REQ-002 SHALL have parameter DEPTH, default 4, meaning entries per FIFO; legal values are powers of 2 from 2 to 16.
REQ-003 SHALL have parameter TIMEOUT, default 255, meaning the maximum PCLK cycles spent in WAIT (8-bit range, 1-255).
REQ-004 SHALL have port PCLK, input, 1 bit, system clock.
REQ-005 SHALL have port PRESET, input, 1 bit, synchronous active-high reset.
REQ-006 SHALL have port SEQ_EN, input, 1 bit, allows new transfers to be launched.
REQ-007 SHALL have ports TX_WR_EN (input, 1 bit) and TX_WDATA (input, 8 bits), which push a byte into the TX FIFO.
REQ-008 SHALL have ports RX_RD_EN (input, 1 bit, pops the RX FIFO) and RX_RDATA (output, 8 bits, RX FIFO head, show-ahead).
REQ-009 SHALL have outputs TX_FULL, TX_EMPTY, RX_FULL and RX_EMPTY, each 1 bit, giving FIFO status.
REQ-010 SHALL have outputs TX_LEVEL and RX_LEVEL, each log2(DEPTH)+1 bits, giving FIFO occupancy.
REQ-011 SHALL have output ERR, 3 bits, sticky: bit[0] TX push dropped, bit[1] RX pop while empty, bit[2] WAIT timeout.
REQ-012 SHALL have input ERR_CLR, 3 bits, write-1-to-clear per ERR bit.
REQ-013 SHALL have output SPI_DATA, 8 bits, byte presented to the SPI master DATA_SHIFT_REG input.
REQ-014 SHALL have outputs SPI_SEL_DATA and SPI_SEL_CMD, each 1 bit, single-cycle load and start strobes to the SPI master.
REQ-015 SHALL have inputs SPI_RX_PULSE (1 bit, end-of-session pulse from the master) and SPI_RX_DATA (8 bits, master RX_REG).
REQ-016 SHALL have output BUSY, 1 bit, high whenever the FSM state is not IDLE.

Function
REQ-017 SHALL implement the FSM states IDLE, LOAD, START, WAIT and CAPTURE.
REQ-018 SHALL move from IDLE to LOAD when SEQ_EN=1, TX_EMPTY=0 and RX_FULL=0; otherwise the FSM SHALL stay in IDLE.
REQ-019 SHALL, in LOAD (1 cycle), drive SPI_DATA with the TX head, assert SPI_SEL_DATA=1, pop the TX FIFO, and go to START.
REQ-020 SHALL, in START (1 cycle), assert SPI_SEL_CMD=1, hold SPI_DATA, clear the timeout counter, and go to WAIT.
REQ-021 SHALL, in WAIT, increment the timeout counter each cycle; on SPI_RX_PULSE=1 it SHALL go to CAPTURE.
REQ-022 SHALL, when the timeout counter reaches TIMEOUT in WAIT without a pulse, set ERR[2], skip the RX write, and go to IDLE.
REQ-023 SHALL, in CAPTURE (1 cycle, the cycle after the pulse, when master RX_REG is valid), write SPI_RX_DATA into the RX FIFO and go to IDLE.
REQ-024 SHALL ignore SPI_RX_PULSE in every state other than WAIT.
REQ-025 SHALL keep SPI_SEL_DATA and SPI_SEL_CMD at 0 outside LOAD and START, so strobes are never adjacent to an active session.
REQ-026 SHALL, when SEQ_EN falls mid-transfer, complete the current transfer and then remain in IDLE.
REQ-027 SHALL give a minimum transfer spacing of 1 IDLE cycle between CAPTURE and the next LOAD.
REQ-028 SHALL evaluate TX FIFO fullness at the start of the cycle: a push while TX_FULL=1 is dropped and sets ERR[0], even if LOAD pops in the same cycle.
REQ-029 SHALL let a push and a LOAD pop on a non-full TX FIFO in the same cycle both take effect, leaving TX_LEVEL unchanged.
REQ-030 SHALL ignore an RX pop while RX_EMPTY=1 and set ERR[1].
REQ-031 SHALL let an RX pop and a CAPTURE write in the same cycle both take effect.
REQ-032 SHALL never overflow the RX FIFO, which is guaranteed by the IDLE-exit check in REQ-018.
REQ-033 SHALL wrap FIFO pointers modulo DEPTH; the level counters SHALL carry the full/empty distinction, with FULL meaning level==DEPTH and EMPTY meaning level==0.
REQ-034 SHALL give an ERR set event priority over ERR_CLR for the same bit in the same cycle.

Reset
REQ-035 SHALL, on PRESET=1 at a clock edge, set: state IDLE; FIFO pointers and levels 0; TX_EMPTY=1, RX_EMPTY=1, TX_FULL=0, RX_FULL=0; ERR=0; SPI_DATA=0x00; SPI_SEL_DATA=0, SPI_SEL_CMD=0; BUSY=0; timeout counter 0.
REQ-036 SHALL, on reset mid-transfer, abandon the transfer, discard FIFO contents, and generate no further strobes.
REQ-037 SHALL let RX_RDATA be 0x00 after reset; its value while RX_EMPTY=1 is otherwise don't-care.

Verification
REQ-038 SHALL cover a single transfer: push 0xA5 with SEQ_EN=1, then pulse SPI_RX_PULSE with SPI_RX_DATA=0x3C -> SEL_DATA with SPI_DATA=0xA5, SEL_CMD the next cycle, RX_RDATA=0x3C, RX_LEVEL=1, BUSY=0.
REQ-039 SHALL cover back-to-back transfers: with DEPTH=4, push 0x01, 0x02, 0x03 and respond to each -> 3 transfers in order, RX_LEVEL=3, TX_EMPTY=1.
REQ-040 SHALL cover a TX FIFO full drop: SEQ_EN=0, push 5 bytes -> TX_LEVEL=4, TX_FULL=1, ERR[0]=1; ERR_CLR=3'b001 -> ERR=0.
REQ-041 SHALL cover RX FIFO full stall: fill RX to 4 -> no LOAD while TX is non-empty; one RX pop -> LOAD the next cycle.
REQ-042 SHALL cover a timeout: TIMEOUT=10, no SPI_RX_PULSE -> IDLE after 10 WAIT cycles, ERR[2]=1, RX_LEVEL unchanged.
REQ-043 SHALL cover reset in WAIT: PRESET=1 -> the next cycle shows BUSY=0 and all levels 0; a late SPI_RX_PULSE writes nothing.
